seq_div: RTL and testbench

- Iterative restoring divider: 16-bit dividend by 8-bit divisor, giving a 16-bit quotient and an 8-bit remainder.
- Inverse companion to the segmented exact/approximate 8x8 multiplier datapath. Used to check multiplier products and to undo scaling in the same approximate-arithmetic experiments.
- Computes one quotient bit per cycle, MSB first.
- Optional approximate mode skips the last APPROX_BITS iterations. This trades accuracy for latency, in the same way the approximate multipliers drop low-order bits.

---
 rtl/seq_div_pkg.sv | 12 +
 rtl/seq_div_div_step.sv | 21 ++
 rtl/seq_div.sv | 133 +++++++++++++
 tb/tb_seq_div.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
package seq_div_pkg;
    localparam int DW = 16;
    localparam int VW = 8;
    localparam logic [DW-1:0] DBZ_QUOTIENT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_div_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step
    import seq_div_pkg::*;
(
    input  logic [VW:0]   pr_in,
    input  logic          dvd_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   pr_out,
    output logic          q_bit
);
    localparam int PW = VW + 1;

    logic [VW+1:0] shifted;

    // pr_in[VW] is always 0 between steps; the extra bit keeps the compare exact.
    always_comb begin
        shifted = {pr_in, dvd_bit};
        q_bit   = (shifted >= {2'b00, divisor});
        pr_out  = q_bit ? PW'(shifted - {2'b00, divisor}) : shifted[VW:0];
    end
endmodule

// File: rtl/seq_div.sv
// 16/8 unsigned restoring divider, one quotient bit per cycle; optional skipped LSB iterations.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int APPROX_BITS = 0  // legal 0..8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);
    localparam logic [4:0] ITERS = 5'(DW - APPROX_BITS);

    state_t        state_q, state_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] divisor_q, divisor_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic [VW:0]   pr_q, pr_d;
    logic [4:0]    count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   pr_step;
    logic          q_bit;
    logic [DW-1:0] q_shift;

    div_step u_step (
        .pr_in   (pr_q),
        .dvd_bit (dvd_q[DW-1]),
        .divisor (divisor_q),
        .pr_out  (pr_step),
        .q_bit   (q_bit)
    );

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        quotient_d  = quotient_q;
        divisor_d   = divisor_q;
        remainder_d = remainder_q;
        pr_d        = pr_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        dbz_d       = dbz_q;
        q_shift     = {quotient_q[DW-2:0], q_bit};

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    dvd_d      = dividend;
                    divisor_d  = divisor;
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = DBZ_QUOTIENT;
                        remainder_d = dividend[VW-1:0];
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        pr_d       = '0;
                        quotient_d = '0;
                        count_d    = ITERS;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                pr_d       = pr_step;
                dvd_d      = {dvd_q[DW-2:0], 1'b0};
                quotient_d = q_shift;
                count_d    = count_q - 5'd1;
                // Skipped iterations leave zero-filled quotient LSBs.
                if (count_q == 5'd1) begin
                    state_d     = DONE;
                    quotient_d  = q_shift << APPROX_BITS;
                    remainder_d = pr_step[VW-1:0];
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            quotient_q  <= '0;
            divisor_q   <= '0;
            remainder_q <= '0;
            pr_q        <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            quotient_q  <= quotient_d;
            divisor_q   <= divisor_d;
            remainder_q <= remainder_d;
            pr_q        <= pr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench: exact (APPROX_BITS=0) and approximate (APPROX_BITS=4) dividers side by side.
module tb_seq_div;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] dividend  [2];
    logic [7:0]  divisor   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] quotient  [2];
    logic [7:0]  remainder [2];
    logic        dbz       [2];

    seq_div #(.APPROX_BITS(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .dividend(dividend[0]), .divisor(divisor[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .quotient(quotient[0]), .remainder(remainder[0]),
        .div_by_zero(dbz[0])
    );
    seq_div #(.APPROX_BITS(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .dividend(dividend[1]), .divisor(divisor[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .quotient(quotient[1]), .remainder(remainder[1]),
        .div_by_zero(dbz[1])
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        mon_en;
    logic        pend    [2];
    logic        seen    [2];
    logic [15:0] exp_q   [2];
    logic [7:0]  exp_r   [2];
    logic        exp_dbz [2];
    int          exp_lat [2];
    int          acc_cyc [2];

    function automatic int abits(input int u);
        return (u == 0) ? 0 : 4;
    endfunction

    // Reference: {dbz, quotient, remainder} from plain integer arithmetic.
    function automatic logic [24:0] model(input logic [15:0] a, input logic [7:0] b, input int sh);
        int x, q, r;
        if (b == 8'd0) return {1'b1, 16'hFFFF, a[7:0]};
        x = int'(a) >> sh;
        q = (x / int'(b)) << sh;
        r = x % int'(b);
        return {1'b0, q[15:0], r[7:0]};
    endfunction

    task automatic chk(input string name, input int u, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s u%0d got=%0h want=%0h", name, u, got, want);
        end
    endtask

    // Compare process: every cycle, each unit's outputs against the pending expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int u = 0; u < 2; u++) begin
                if (!pend[u]) begin
                    chk("idle_out_valid", u, out_valid[u], 0);
                end else if (out_valid[u] === 1'b1) begin
                    if (!seen[u]) begin
                        chk("latency", u, cyc - acc_cyc[u], exp_lat[u]);
                        seen[u] = 1'b1;
                    end
                    chk("quotient", u, quotient[u], exp_q[u]);
                    chk("remainder", u, remainder[u], exp_r[u]);
                    chk("div_by_zero", u, dbz[u], exp_dbz[u]);
                end
            end
        end
    end

    // Called at posedge+2. Latency counts edges from the accept edge to out_valid visible.
    task automatic do_op(input int u, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                         input int elat, input int hold, input bit stray);
        int n;
        dividend[u] = a;
        divisor[u]  = b;
        in_valid[u] = 1'b1;
        exp_q[u] = eq; exp_r[u] = er; exp_dbz[u] = edbz; exp_lat[u] = elat;
        seen[u] = 1'b0;
        pend[u] = 1'b1;
        n = 0;
        while (in_ready[u] !== 1'b1 && n < 40) begin @(posedge clk); #2; n++; end
        if (n >= 40) chk("accept_timeout", u, in_ready[u], 1);
        acc_cyc[u] = cyc + 1;
        @(posedge clk); #2;
        in_valid[u] = 1'b0;
        n = 0;
        while (out_valid[u] !== 1'b1 && n < 40) begin @(posedge clk); #2; n++; end
        if (n >= 40) chk("result_timeout", u, out_valid[u], 1);
        for (int h = 0; h < hold; h++) begin
            if (stray) begin
                in_valid[u] = 1'b1; dividend[u] = 16'd50; divisor[u] = 8'd5;
            end
            chk("in_ready_in_done", u, in_ready[u], 0);
            chk("out_valid_held", u, out_valid[u], 1);
            @(posedge clk); #2;
        end
        out_ready[u] = 1'b1;
        @(posedge clk); #2;
        out_ready[u] = 1'b0;
        pend[u] = 1'b0;
        chk("out_valid_drop", u, out_valid[u], 0);
        chk("in_ready_back", u, in_ready[u], 1);
        $display("op u%0d %0d/%0d expect q=%0d r=%0d dbz=%0d lat=%0d", u, a, b, eq, er, edbz, elat);
    endtask

    task automatic model_op(input int u, input logic [15:0] a, input logic [7:0] b);
        logic [24:0] m;
        m = model(a, b, abits(u));
        do_op(u, a, b, m[23:8], m[7:0], m[24], m[24] ? 0 : 16 - abits(u), 0, 0);
    endtask

    initial begin
        logic [24:0] m;
        logic [15:0] ra;
        logic [7:0]  rb;
        rst_n = 1'b0;
        mon_en = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0; out_ready[u] = 1'b0; dividend[u] = '0; divisor[u] = '0;
            pend[u] = 1'b0; seen[u] = 1'b0; exp_q[u] = '0; exp_r[u] = '0; exp_dbz[u] = 1'b0;
            exp_lat[u] = 0; acc_cyc[u] = 0;
        end

        // Hand-computed pins on the reference model.
        m = model(16'd1000, 8'd7, 0);    chk("model_1000_7_a0", 0, m, {1'b0, 16'd142, 8'd6});
        m = model(16'd1000, 8'd7, 4);    chk("model_1000_7_a4", 1, m, {1'b0, 16'd128, 8'd6});
        m = model(16'd65535, 8'd255, 0); chk("model_65535_255", 0, m, {1'b0, 16'd257, 8'd0});
        m = model(16'd100, 8'd0, 0);     chk("model_dbz", 0, m, {1'b1, 16'hFFFF, 8'h64});

        repeat (3) @(posedge clk);
        #2;
        for (int u = 0; u < 2; u++) begin
            chk("rst_in_ready", u, in_ready[u], 1);
            chk("rst_out_valid", u, out_valid[u], 0);
            chk("rst_quotient", u, quotient[u], 0);
            chk("rst_remainder", u, remainder[u], 0);
            chk("rst_dbz", u, dbz[u], 0);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #2;

        do_op(0, 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 0, 0);
        do_op(0, 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16, 0, 0);
        do_op(0, 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 16, 0, 0);
        do_op(0, 16'd0, 8'd3, 16'd0, 8'd0, 1'b0, 16, 0, 0);
        do_op(0, 16'd200, 8'd1, 16'd200, 8'd0, 1'b0, 16, 0, 0);
        do_op(0, 16'd100, 8'd0, 16'hFFFF, 8'h64, 1'b1, 0, 0, 0);
        do_op(1, 16'd1000, 8'd7, 16'd128, 8'd6, 1'b0, 12, 0, 0);
        do_op(1, 16'd100, 8'd0, 16'hFFFF, 8'h64, 1'b1, 0, 0, 0);

        // Backpressure with a competing request held during DONE.
        do_op(0, 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 10, 1);
        do_op(0, 16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 16, 0, 0);

        // Reset after five CALC edges drops the result.
        dividend[0] = 16'd1000; divisor[0] = 8'd7; in_valid[0] = 1'b1;
        @(posedge clk); #2;
        in_valid[0] = 1'b0;
        repeat (5) begin @(posedge clk); #2; end
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk("midrst_in_ready", 0, in_ready[0], 1);
        chk("midrst_out_valid", 0, out_valid[0], 0);
        chk("midrst_quotient", 0, quotient[0], 0);
        rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #2; end
        do_op(0, 16'd91, 8'd13, 16'd7, 8'd0, 1'b0, 16, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = (i % 50 == 7) ? 8'd0 : 8'($urandom_range(1, 255));
            model_op(1, ra, rb);
        end
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = (i % 40 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
            model_op(0, ra, rb);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
